scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_seq_pkg.sv | 46 ++++
 rtl/scan_dwell_timer.sv | 36 +++
 rtl/scan_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_scan_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// ============================================================================
// Module      : scan_seq_pkg
// Description : Shared types, widths and digit-search helper for the scan
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_seq_pkg;

    localparam int c_DIGIT_W    = 3;
    localparam int c_CNT_W      = 8;
    localparam int c_NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [c_DIGIT_W-1:0] digit;
    } digit_sel_t;

    // Lowest unmasked digit at or above 'from'; from = 8 always yields none.
    function automatic digit_sel_t next_unmasked(
        input logic [c_NUM_DIGITS-1:0] mask,
        input logic [c_DIGIT_W:0]      from
    );
        digit_sel_t sel;
        sel.found = 1'b0;
        sel.digit = '0;
        for (int i = c_NUM_DIGITS - 1; i >= 0; i--) begin
            if (!mask[i] && (i >= int'(from))) begin
                sel.found = 1'b1;
                sel.digit = c_DIGIT_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_dwell_timer.sv
// ============================================================================
// Module      : scan_dwell_timer
// Description : Loadable down-counter with terminal-count flag, shared by the
//               blanking and drive phases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/scan_sequencer.sv
// ============================================================================
// Module      : scan_sequencer
// Description : Multiplexed 8-digit scan sequencer driving a 3-to-8 decoder
//               with blanking, dwell, single-pass and continuous modes.
//               Optional digit skipping enabled by macro SCAN_SEQ_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
`ifdef SCAN_SEQ_SKIP_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       frame_wrap
);

    localparam logic [c_CNT_W-1:0] c_DWELL_LD = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LD =
        c_CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    // With no blanking, each digit is entered straight into its drive phase.
    localparam state_t             c_ENTER_ST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
    localparam logic [c_CNT_W-1:0] c_ENTER_LD = (BLANK_CYCLES > 0) ? c_BLANK_LD : c_DWELL_LD;

    state_t                     r_state;
    logic [c_DIGIT_W-1:0]       r_digit;
    logic                       r_cont;
    logic [c_DIGIT_W-1:0]       r_abc;
    logic                       r_en;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_wrap;

    state_t                     w_state_nxt;
    logic [c_DIGIT_W-1:0]       w_digit_nxt;
    logic                       w_cont_nxt;
    logic                       w_load;
    logic [c_CNT_W-1:0]         w_load_val;
    logic                       w_dec;
    logic                       w_wrap;
    logic                       w_tc;
    logic [c_NUM_DIGITS-1:0]    w_mask;
    digit_sel_t                 w_first;
    digit_sel_t                 w_after;

`ifdef SCAN_SEQ_SKIP_EN
    assign w_mask = skip_mask;
`else
    assign w_mask = '0;
`endif

    assign w_first = next_unmasked(w_mask, '0);
    assign w_after = next_unmasked(w_mask, {1'b0, r_digit} + 4'd1);

    scan_dwell_timer #(
        .CNT_W      (c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cont_nxt  = r_cont;
        w_load      = 1'b0;
        w_load_val  = c_ENTER_LD;
        w_dec       = 1'b0;
        w_wrap      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_digit_nxt = '0;
                if (start) begin
                    w_cont_nxt = cont;
                    if (w_first.found) begin
                        w_state_nxt = c_ENTER_ST;
                        w_digit_nxt = w_first.digit;
                        w_load      = 1'b1;
                    end else if (!cont) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_BLANK: begin
                if (w_tc) begin
                    w_state_nxt = ST_DRIVE;
                    w_load      = 1'b1;
                    w_load_val  = c_DWELL_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (!w_tc) begin
                    w_dec = 1'b1;
                end else if (w_after.found) begin
                    w_state_nxt = c_ENTER_ST;
                    w_digit_nxt = w_after.digit;
                    w_load      = 1'b1;
                end else if (r_cont && w_first.found) begin
                    w_state_nxt = c_ENTER_ST;
                    w_digit_nxt = w_first.digit;
                    w_load      = 1'b1;
                    w_wrap      = 1'b1;
                end else begin
                    // Mask may have changed mid-pass and left nothing to wrap to.
                    w_state_nxt = r_cont ? ST_IDLE : ST_DONE;
                    w_digit_nxt = '0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_digit_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_digit_nxt = '0;
            end
        endcase

        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_digit_nxt = '0;
            w_cont_nxt  = 1'b0;
            w_load      = 1'b1;
            w_load_val  = '0;
            w_dec       = 1'b0;
            w_wrap      = 1'b0;
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_digit <= '0;
            r_cont  <= 1'b0;
            r_abc   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_cont  <= w_cont_nxt;
            r_abc   <= ((w_state_nxt == ST_BLANK) || (w_state_nxt == ST_DRIVE)) ? w_digit_nxt : '0;
            r_en    <= (w_state_nxt == ST_DRIVE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_wrap  <= w_wrap;
        end
    end

    assign A          = r_abc[2];
    assign B          = r_abc[1];
    assign C          = r_abc[0];
    assign en         = r_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign frame_wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Scoreboard bench for scan_sequencer (DWELL=4, BLANK=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] skip_mask = 8'h00;
    logic       A, B, C, en, busy, done, frame_wrap;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        string      tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_sequencer #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
`ifdef SCAN_SEQ_SKIP_EN
        .skip_mask  (skip_mask),
`endif
        .A          (A),
        .B          (B),
        .C          (C),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .frame_wrap (frame_wrap)
    );

    // Vector layout: {ABC[2:0], en, busy, done, frame_wrap}; cycle 1 follows start.
    function automatic logic [6:0] model(input int c, input bit contm);
        int         cc;
        int         d;
        int         r;
        logic       w;
        logic [2:0] dg;
        if (!contm && c == 49) return 7'b000_0_1_1_0;
        if (!contm && c > 49)  return 7'b0;
        cc = ((c - 1) % 48) + 1;
        w  = contm && (c > 48) && (cc == 1);
        d  = (cc - 1) / 6;
        r  = (cc - 1) % 6;
        dg = 3'(d);
        return {dg, (r >= 2), 1'b1, 1'b0, w};
    endfunction

    task automatic push(input int k, input logic [6:0] v, input string tag);
        exp_t e;
        e.cyc = base + k;
        e.vec = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_model(input int from, input int to, input bit contm, input string tag);
        for (int k = from; k <= to; k++) push(k, model(k, contm), tag);
    endtask

    task automatic push_zero(input int from, input int to, input string tag);
        for (int k = from; k <= to; k++) push(k, 7'b0, tag);
    endtask

    task automatic kick(input bit c);
        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        cont  = c;
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] obs;
        obs = {A, B, C, en, busy, done, frame_wrap};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: cycle %0d not sampled (now %0d)", e.tag, e.cyc - base, cyc);
            end else if (obs !== e.vec) begin
                bad++;
                $display("FAIL %s @%0d: got abc_en_busy_done_wrap=%b required=%b",
                         e.tag, cyc - base, obs, e.vec);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        base = cyc;
        rst  = 1'b0;
        push_zero(0, 2, "reset_state");
        wait_to(3);

        kick(1'b0);
        push_model(1, 50, 1'b0, "single_pass");
        push_zero(51, 52, "single_idle");
        @(negedge clk);
        start = 1'b0;
        wait_to(53);

        kick(1'b1);
        push_model(1, 54, 1'b1, "continuous");
        push_zero(55, 57, "cont_stop");
        @(negedge clk);
        start = 1'b0;
        wait_to(54);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(58);

        kick(1'b0);
        push_model(1, 22, 1'b0, "pre_stop");
        push_zero(23, 55, "after_stop");
        @(negedge clk);
        start = 1'b0;
        wait_to(22);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(56);

        @(negedge clk);
        base  = cyc;
        start = 1'b1;
        stop  = 1'b1;
        push_zero(1, 4, "start_and_stop");
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wait_to(5);

        kick(1'b0);
        push_model(1, 51, 1'b0, "start_while_busy");
        @(negedge clk);
        start = 1'b0;
        wait_to(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(52);

        kick(1'b1);
        push_model(1, 20, 1'b1, "pre_reset");
        push_zero(21, 26, "mid_scan_reset");
        @(negedge clk);
        start = 1'b0;
        wait_to(20);
        rst = 1'b1;
        wait_to(23);
        rst = 1'b0;
        wait_to(27);

`ifdef SCAN_SEQ_SKIP_EN
        skip_mask = 8'h55;
        kick(1'b0);
        for (int k = 1; k <= 24; k++) begin
            logic [2:0] dg;
            dg = 3'(2 * ((k - 1) / 6) + 1);
            push(k, {dg, (((k - 1) % 6) >= 2), 1'b1, 1'b0, 1'b0}, "skip_55");
        end
        push(25, 7'b000_0_1_1_0, "skip_55_done");
        push_zero(26, 27, "skip_55_idle");
        @(negedge clk);
        start = 1'b0;
        wait_to(28);

        skip_mask = 8'hFF;
        kick(1'b0);
        push(1, 7'b000_0_1_1_0, "skip_ff_done");
        push_zero(2, 3, "skip_ff_idle");
        @(negedge clk);
        start = 1'b0;
        wait_to(4);

        kick(1'b1);
        push_zero(1, 3, "skip_ff_cont");
        @(negedge clk);
        start = 1'b0;
        wait_to(4);
        skip_mask = 8'h00;
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
